// File: rtl/fc_requant_serializer.sv
// fc_requant_serializer
//   Captures one parallel vector of post-ReLU fully-connected accumulator
//   results, one per neuron, in a single handshake. Each element is
//   requantized to WIDTH bits: a round-half-up right shift by SHIFT, then
//   saturation to [0, 2^(WIDTH-1)-1]. The results are streamed one element
//   per beat over a valid/ready interface.
//
//   Optional feature macro: FC_REQUANT_ARGMAX_EN
//     Tracks the argmax of the quantized stream. On a tie the lowest index
//     wins. argmax_valid pulses for one cycle after the last beat.
//     When the macro is undefined, argmax_idx and argmax_valid are tied to 0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   parallel vector handshake
//   in_data             N_NEURON*ACC_W bits; neuron k at [k*ACC_W +: ACC_W]
//   out_valid/out_ready element stream handshake
//   out_data            requantized element (signed, never negative)
//   out_idx             neuron index of out_data
//   out_last            high with the final element of a vector
//   argmax_idx          index of the largest element of the last vector
//   argmax_valid        one-cycle pulse when argmax_idx updates
module fc_requant_serializer #(
  parameter  int WIDTH    = 8,
  parameter  int ACC_W    = 23,
  parameter  int N_NEURON = 84,
  parameter  int SHIFT    = 8,
  localparam int IDX_W    = $clog2(N_NEURON)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_NEURON*ACC_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic [IDX_W-1:0]          argmax_idx,
  output logic                      argmax_valid
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_NEURON - 1);
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] SAT_EXT = (ACC_W+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'((1 << (WIDTH-1)) - 1);

  // Round-half-up shift, done one bit wider so the rounding add cannot wrap.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] sum;
    sum = {v[ACC_W-1], v} + RND;
    return sum >>> SHIFT;
  endfunction

  // Negative inputs clamp to 0 (ReLU should never produce them).
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v,
                                                        input logic signed [ACC_W:0] r);
    if (v < 0)             return '0;
    else if (r > SAT_EXT)  return SAT_MAX;
    else                   return r[WIDTH-1:0];
  endfunction

  state_t                   state, state_nxt;
  logic [N_NEURON*ACC_W-1:0] cap_p0;
  logic                     take, beat, at_end;
  logic [IDX_W-1:0]         idx_nxt, sel_idx;
  logic signed [ACC_W-1:0]  elem0, elem_nxt;
  logic signed [WIDTH-1:0]  q_first, q_nxt;

  // ---- control: FSM ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SEND;
      SEND:    if (out_ready && at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);
  assign at_end    = (out_idx == LAST_IDX);
  assign out_last  = at_end && out_valid;
  assign take      = in_ready && in_valid;
  assign beat      = out_valid && out_ready;

  // ---- stage p0: capture register and element select ----
  always_ff @(posedge clk) begin
    if (take) cap_p0 <= in_data;
  end

  always_comb begin
    idx_nxt  = out_idx + 1'b1;
    // Keep the select in range on the last element; its result is unused then.
    sel_idx  = at_end ? '0 : idx_nxt;
    elem0    = in_data[ACC_W-1:0];
    elem_nxt = cap_p0[sel_idx*ACC_W +: ACC_W];
    q_first  = saturate(elem0, round_shift(elem0));
    q_nxt    = saturate(elem_nxt, round_shift(elem_nxt));
  end

  // ---- stage p1: registered output element ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_idx  <= '0;
    end else if (take) begin
      out_data <= q_first;
      out_idx  <= '0;
    end else if (beat && !at_end) begin
      out_data <= q_nxt;
      out_idx  <= idx_nxt;
    end
  end

`ifdef FC_REQUANT_ARGMAX_EN
  logic signed [WIDTH-1:0] max_val;
  logic [IDX_W-1:0]        max_idx;
  logic                    gt;

  // Strictly greater only, so the earliest index keeps a tie.
  assign gt = (out_data > max_val);

  always_ff @(posedge clk) begin
    if (take) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (beat && gt) begin
      max_val <= out_data;
      max_idx <= out_idx;
    end
  end

  // ---- stage p2: argmax result ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      argmax_valid <= 1'b0;
      argmax_idx   <= '0;
    end else begin
      argmax_valid <= 1'b0;
      if (beat && at_end) begin
        argmax_valid <= 1'b1;
        argmax_idx   <= gt ? out_idx : max_idx;
      end
    end
  end
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_requant_serializer.sv
// Directed testbench for fc_requant_serializer (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fc_requant_serializer;
  localparam int WIDTH = 8;
  localparam int ACC_W = 23;
  localparam int N     = 84;
  localparam int SHIFT = 8;
  localparam int IDX_W = 7;

  logic                 clk = 1'b0;
  logic                 rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic                 argmax_valid;
  logic [N*ACC_W-1:0]   in_data;
  logic [WIDTH-1:0]     out_data;
  logic [IDX_W-1:0]     out_idx, argmax_idx;

  int n_chk  = 0;
  int n_pass = 0;
  int vec[N];
  int exp_v[N];

  always #5 clk = ~clk;

  fc_requant_serializer #(
    .WIDTH(WIDTH), .ACC_W(ACC_W), .N_NEURON(N), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic load_vec();
    for (int k = 0; k < N; k++) in_data[k*ACC_W +: ACC_W] = vec[k][ACC_W-1:0];
  endtask

  // Present vec; returns on the negedge after capture (first beat visible).
  task automatic send(input bit hold);
    load_vec();
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  // Consume one vector; mode 1 applies the 1,0,0,1 ready pattern.
  task automatic recv(input int mode, input int exp_arg);
    int cnt = 0;
    int cyc = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (cnt < N && cyc < 1000) begin
      out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
      check("out_valid", out_valid, 1);
      if (!out_valid) break;
      check("out_data", out_data, exp_v[cnt]);
      check("out_idx", out_idx, cnt);
      check("out_last", out_last, cnt == N-1);
      if (out_ready) cnt++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("beats", cnt, N);
    check("done_in_ready", in_ready, 1);
    check("done_out_valid", out_valid, 0);
`ifdef FC_REQUANT_ARGMAX_EN
    check("argmax_valid", argmax_valid, 1);
    check("argmax_idx", argmax_idx, exp_arg);
    @(negedge clk);
    check("argmax_pulse", argmax_valid, 0);
    check("argmax_hold", argmax_idx, exp_arg);
`else
    check("argmax_valid_off", argmax_valid, 0);
    check("argmax_idx_off", argmax_idx, 0);
    if (exp_arg < 0) check("argmax_arg", exp_arg, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_argmax_idx", argmax_idx, 0);
    check("rst_argmax_valid", argmax_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Ramp: element k = k<<8 -> k
    for (int k = 0; k < N; k++) begin vec[k] = k << 8; exp_v[k] = k; end
    send(1'b0);
    recv(0, 83);

    // Rounding, saturation, negative clamp, full-scale positive
    for (int k = 0; k < N; k++) begin vec[k] = k << 8; exp_v[k] = k; end
    vec[0] = 'h17F;    exp_v[0] = 1;
    vec[1] = 'h180;    exp_v[1] = 2;
    vec[2] = 'h7FFF;   exp_v[2] = 127;
    vec[3] = 'h7FFFFF; exp_v[3] = 0;
    vec[4] = 'h3FFFFF; exp_v[4] = 127;
    send(1'b0);
    recv(0, 2);

    // Backpressure with rounding up by half: (83-k)<<8 + 0x80 -> 84-k
    for (int k = 0; k < N; k++) begin vec[k] = ((83 - k) << 8) + 'h80; exp_v[k] = 84 - k; end
    send(1'b0);
    recv(1, 0);

    // in_valid held during SEND with a different vector on in_data
    for (int k = 0; k < N; k++) begin vec[k] = k << 8; exp_v[k] = k; end
    send(1'b1);
    for (int k = 0; k < N; k++) vec[k] = (k + 10) << 8;
    load_vec();
    recv(0, 83);
    for (int i = 0; i < 5 && !out_valid; i++) @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) exp_v[k] = k + 10;
    recv(0, 83);

    // Reset in the middle of a vector, at beat 40
    for (int k = 0; k < N; k++) begin vec[k] = k << 8; exp_v[k] = k; end
    send(1'b0);
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'b1;
      check("pre_rst_idx", out_idx, i);
      @(negedge clk);
    end
    check("at_rst_idx", out_idx, 40);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_out_data", out_data, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_quiet", out_valid, 0);
    send(1'b0);
    recv(0, 83);

    // Tie for the maximum: 5 at idx 10 and idx 60
    for (int k = 0; k < N; k++) begin vec[k] = 0; exp_v[k] = 0; end
    vec[10] = 5 << 8; exp_v[10] = 5;
    vec[60] = 5 << 8; exp_v[60] = 5;
    send(1'b0);
    recv(0, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fc_requant_serializer.md
Name: fc_requant_serializer

Overview:
- Sits directly downstream of the fully-connected `layer` neurons.
- Captures one parallel vector of post-ReLU accumulator results, one per neuron, in a single handshake.
- Requantizes each value to WIDTH bits with round-half-up right shift and saturation.
- Streams the results one per beat over a valid/ready interface to the next layer's input collector.

Parameters:
- WIDTH, 8, activation width; the output element is WIDTH bits.
- ACC_W, 23, accumulator width per neuron. Equals WIDTH*2+$clog2(fan-in), which is 16+7 for fc2.
- N_NEURON, 84, number of neuron results per vector.
- SHIFT, 8, requantization right shift; legal range 0..ACC_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  parallel vector present.
- in_ready  output  1  block can accept a vector.
- in_data  input  N_NEURON*ACC_W  flattened results; neuron k occupies bits [k*ACC_W +: ACC_W].
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  requantized element.
- out_idx  output  $clog2(N_NEURON)  neuron index of out_data.
- out_last  output  1  high with the final element of a vector.
- argmax_idx  output  $clog2(N_NEURON)  see Optional Feature.
- argmax_valid  output  1  see Optional Feature.

Behaviour:
- Reset: rst_n is sampled on the rising edge of clk, synchronous, active low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, argmax_idx=0, argmax_valid=0. The capture register is not cleared.
- Reset mid-stream abandons the vector; no further beats are emitted.
- States are IDLE and SEND.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the capture register, go to SEND, and set out_data=q(0), out_idx=0, out_valid=1.
  - Out_valid therefore rises on the cycle after capture, giving 1-cycle latency.
- SEND:
  - in_ready=0; in_valid is ignored.
  - out_valid stays high and out_data/out_idx/out_last stay stable until out_valid&&out_ready.
  - On a handshake with out_idx<N_NEURON-1: load out_idx+1 and q(out_idx+1).
  - On a handshake with out_idx==N_NEURON-1: out_valid=0, go to IDLE. in_ready returns to 1 on the following cycle, so there is no same-cycle capture.
- out_last = (out_idx==N_NEURON-1) && out_valid.
- With out_ready held high, the block sustains 1 element/cycle. A vector occupies N_NEURON cycles plus 1 idle cycle.
- Requantization q(k), with v = element k treated as signed ACC_W bits:
  - If v<0: result 0. This is a defensive clamp; ReLU should never produce it.
  - Else r = (v + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT. Compute in ACC_W+1 bits so the rounding addition cannot overflow.
  - If r > 2^(WIDTH-1)-1: result 2^(WIDTH-1)-1, i.e. 127 at WIDTH=8.
  - Else result r.
- Output is a non-negative signed WIDTH-bit value, directly consumable as the next layer's x element.
- out_data is registered; there is no combinational path from in_data or out_ready to out_data.

Optional Feature:
- Macro: FC_REQUANT_ARGMAX_EN.
- When defined:
  - A running max tracks the quantized values of accepted beats.
  - A strictly greater value replaces the max, so on ties the lowest index wins.
  - On the cycle after the last beat's handshake: argmax_valid pulses high for exactly 1 cycle and argmax_idx holds the winning index until the next vector's last beat.
  - The tracker resets at each capture.
- When undefined: argmax_idx=0 and argmax_valid=0 constantly; no tracker logic is built.

Test Plan:
- Reset then vector: in_valid with element k = k<<8 (SHIFT=8), out_ready=1 -> out_data sequence 0,1,…,83; out_last only at idx 83; in_ready=1 one cycle after idx 83 is accepted.
- Rounding/saturation: elements 0x17F, 0x180, 0x7FFF, 0x7FFFFF (negative) -> out_data 1, 2, 127, 0.
- Backpressure: out_ready toggles 1,0,0,1 per cycle -> out_data/out_idx stable while stalled; no element dropped or duplicated; 84 beats total.
- in_valid held high during SEND -> no recapture; the second vector is captured only after return to IDLE, and its first beat matches its own element 0.
- rst_n=0 at beat 40 for 1 cycle -> next cycle out_valid=0, in_ready=1; a new vector streams from idx 0.
- With FC_REQUANT_ARGMAX_EN: values 5 at idx 10 and 5 at idx 60, rest 0 -> argmax_idx=10, argmax_valid a single pulse after idx 83 is accepted.
